// File: rtl/irq_pend_ctrl_pkg.sv
// Shared widths and the service-FSM state type for the interrupt pending controller.
package irq_pkg;
    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/irq_pend_ctrl_sync_edge.sv
// Multi-flop synchroniser per request line plus one delay flop for rising-edge detection.
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] s,
    output logic [W-1:0] set
);
    logic [W-1:0] chain_reg [SYNC_STAGES];
    logic [W-1:0] s_d_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg[0] <= '0;
        end else begin
            chain_reg[0] <= d;
        end
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                chain_reg[gi] <= '0;
            end else begin
                chain_reg[gi] <= chain_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_reg <= '0;
        end else begin
            s_d_reg <= chain_reg[SYNC_STAGES-1];
        end
    end

    assign s = chain_reg[SYNC_STAGES-1];

    for (genvar gi = 0; gi < W; gi++) begin : g_edge
        assign set[gi] = s[gi] & ~s_d_reg[gi];
    end
endmodule

// File: rtl/irq_pend_ctrl.sv
// Captures request lines into pending bits, feeds an external priority encoder and
// presents the winning ID on a valid/ack handshake, clearing the served bit on ack.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pend_o,
    output logic             enc_ei,
    input  logic [ID_W-1:0]  enc_y,
    input  logic             enc_gs,
    input  logic             enc_eo,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack,
    output logic [N_REQ-1:0] ovf,
    input  logic             ovf_clr,
    output logic             prot_err
);
    logic [N_REQ-1:0] sync_level;
    logic [N_REQ-1:0] sync_rise;
    logic [N_REQ-1:0] set;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] pend_reg, pend_next;
    logic [N_REQ-1:0] ovf_reg, ovf_next;
    logic             prot_err_reg, prot_err_next;
    logic [ID_W-1:0]  irq_id_reg;
    state_t           state_reg, state_next;
    logic             load_id;
    logic             handshake;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .W          (N_REQ)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (req_in),
        .s  (sync_level),
        .set(sync_rise)
    );

    assign set = (EDGE_MODE != 0) ? sync_rise : sync_level;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a presentation stays put until acknowledged
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en && enc_gs) state_next = PRESENT;
            PRESENT: if (irq_ack)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        load_id   = (state_reg == IDLE) && en && enc_gs;
        handshake = (state_reg == PRESENT) && irq_ack;
        irq_valid = (state_reg == PRESENT);
        clr       = handshake ? id_onehot(irq_id_reg) : '0;
    end

    // Set beats clear on the same bit; an overrun is a set landing on a bit that stays pending
    always_comb begin
        pend_next     = (pend_reg & ~clr) | set;
        ovf_next      = (ovf_clr ? '0 : ovf_reg) | (set & pend_reg & ~clr);
        prot_err_next = prot_err_reg | (en & ~(enc_gs ^ enc_eo)) | (enc_gs & enc_eo);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg     <= '0;
            ovf_reg      <= '0;
            prot_err_reg <= 1'b0;
            irq_id_reg   <= '0;
        end else begin
            pend_reg     <= pend_next;
            ovf_reg      <= ovf_next;
            prot_err_reg <= prot_err_next;
            if (load_id) irq_id_reg <= enc_y;
        end
    end

    assign pend_o   = pend_reg & mask;
    assign enc_ei   = en;
    assign irq_id   = irq_id_reg;
    assign ovf      = ovf_reg;
    assign prot_err = prot_err_reg;
endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Bench for irq_pend_ctrl: directed vector table, corner sequences, then random traffic vs a model.
module tb_irq_pend_ctrl;
    import irq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, ovf_clr, irq_ack, force_bad;
    logic [7:0] req_in, mask;
    logic [7:0] pend_o, ovf;
    logic       enc_ei, enc_gs, enc_eo, irq_valid, prot_err;
    logic [2:0] enc_y, irq_id;

    logic       ack0;
    logic [7:0] req0, pend_o0, ovf0;
    logic       enc_ei0, gs0, eo0, valid0, perr0;
    logic [2:0] y0, id0;

    int n_chk  = 0;
    int n_fail = 0;

    irq_pend_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req_in(req_in), .mask(mask),
        .pend_o(pend_o), .enc_ei(enc_ei), .enc_y(enc_y), .enc_gs(enc_gs), .enc_eo(enc_eo),
        .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
        .ovf(ovf), .ovf_clr(ovf_clr), .prot_err(prot_err)
    );

    irq_pend_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req_in(req0), .mask(mask),
        .pend_o(pend_o0), .enc_ei(enc_ei0), .enc_y(y0), .enc_gs(gs0), .enc_eo(eo0),
        .irq_valid(valid0), .irq_id(id0), .irq_ack(ack0),
        .ovf(ovf0), .ovf_clr(ovf_clr), .prot_err(perr0)
    );

    // Behavioural 8-to-3 priority encoder (bit 7 highest), with a fault-injection override
    always_comb begin
        enc_y = 3'd0; enc_gs = 1'b0; enc_eo = 1'b0;
        if (force_bad) begin
            enc_gs = 1'b1; enc_eo = 1'b1;
        end else if (enc_ei) begin
            if (pend_o != 8'h00) begin
                enc_gs = 1'b1;
                for (int k = 0; k < 8; k++) if (pend_o[k]) enc_y = 3'(k);
            end else begin
                enc_eo = 1'b1;
            end
        end
    end

    always_comb begin
        y0 = 3'd0; gs0 = 1'b0; eo0 = 1'b0;
        if (enc_ei0) begin
            if (pend_o0 != 8'h00) begin
                gs0 = 1'b1;
                for (int k = 0; k < 8; k++) if (pend_o0[k]) y0 = 3'(k);
            end else begin
                eo0 = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [7:0] req;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic [7:0] r, logic a, logic v, logic [2:0] i, logic [7:0] p);
        vec_t t;
        t.req = r; t.ack = a; t.exp_valid = v; t.exp_id = i; t.exp_pend = p;
        return t;
    endfunction

    function automatic logic [2:0] top_bit(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int k = 0; k < 8; k++) if (v[k]) r = 3'(k);
        return r;
    endfunction

    // Model state for the random phase
    logic [7:0] m_pend, m_ovf, m_h[3];
    logic       m_pres;
    logic [2:0] m_id;

    initial begin
        rst = 1'b1; en = 1'b1; ovf_clr = 1'b0; irq_ack = 1'b0; force_bad = 1'b0;
        req_in = 8'h00; mask = 8'hFF; ack0 = 1'b0; req0 = 8'h00;
        steps(3);
        chk("reset_valid", 8'(irq_valid), 8'h00);
        chk("reset_id", 8'(irq_id), 8'h00);
        chk("reset_pend", pend_o, 8'h00);
        chk("reset_ovf", ovf, 8'h00);
        chk("reset_prot", 8'(prot_err), 8'h00);
        rst = 1'b0;
        steps(2);

        // Single capture latency, then priority freeze and re-evaluation after ack
        tbl[0]  = mk(8'h10, 0, 0, 0, 8'h00);
        tbl[1]  = mk(8'h10, 0, 0, 0, 8'h00);
        tbl[2]  = mk(8'h10, 0, 0, 0, 8'h10);
        tbl[3]  = mk(8'h10, 0, 1, 4, 8'h10);
        tbl[4]  = mk(8'h10, 1, 0, 0, 8'h00);
        tbl[5]  = mk(8'h00, 0, 0, 0, 8'h00);
        tbl[6]  = mk(8'h05, 0, 0, 0, 8'h00);
        tbl[7]  = mk(8'h05, 0, 0, 0, 8'h00);
        tbl[8]  = mk(8'h05, 0, 0, 0, 8'h05);
        tbl[9]  = mk(8'h05, 0, 1, 2, 8'h05);
        tbl[10] = mk(8'h85, 0, 1, 2, 8'h05);
        tbl[11] = mk(8'h85, 0, 1, 2, 8'h05);
        tbl[12] = mk(8'h85, 0, 1, 2, 8'h85);
        tbl[13] = mk(8'h85, 0, 1, 2, 8'h85);
        tbl[14] = mk(8'h85, 1, 0, 0, 8'h81);
        tbl[15] = mk(8'h85, 0, 1, 7, 8'h81);
        tbl[16] = mk(8'h85, 1, 0, 0, 8'h01);
        tbl[17] = mk(8'h85, 0, 1, 0, 8'h01);
        tbl[18] = mk(8'h85, 1, 0, 0, 8'h00);
        tbl[19] = mk(8'h00, 0, 0, 0, 8'h00);

        for (int i = 0; i < 20; i++) begin
            req_in = tbl[i].req; irq_ack = tbl[i].ack;
            step();
            $display("vec %0d: req=%h ack=%b -> valid=%b id=%0d pend=%h", i, tbl[i].req, tbl[i].ack,
                     irq_valid, irq_id, pend_o);
            chk($sformatf("vec%0d_pend", i), pend_o, tbl[i].exp_pend);
            chk($sformatf("vec%0d_valid", i), 8'(irq_valid), 8'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk($sformatf("vec%0d_id", i), 8'(irq_id), 8'(tbl[i].exp_id));
        end
        irq_ack = 1'b0;

        // Overrun, clear, and a re-edge coinciding with the ack edge
        en = 1'b0; req_in = 8'h08;
        steps(3);
        chk("ovr_pend", pend_o, 8'h08);
        req_in = 8'h00; steps(2);
        req_in = 8'h08; steps(3);
        chk("ovr_flag", ovf, 8'h08);
        $display("overrun: ovf=%h", ovf);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovr_clear", ovf, 8'h00);
        req_in = 8'h00; steps(2);
        en = 1'b1; step();
        chk("reedge_valid", 8'(irq_valid), 8'h01);
        chk("reedge_id", 8'(irq_id), 8'h03);
        req_in = 8'h08; steps(2);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        $display("re-edge on ack: pend=%h ovf=%h valid=%b", pend_o, ovf, irq_valid);
        chk("reedge_pend", pend_o, 8'h08);
        chk("reedge_ovf", ovf, 8'h00);
        chk("reedge_drop", 8'(irq_valid), 8'h00);
        step();
        chk("reedge_repres", 8'(irq_valid), 8'h01);
        chk("reedge_reid", 8'(irq_id), 8'h03);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        chk("reedge_served", pend_o, 8'h00);

        // Service enable and masking
        req_in = 8'h00; en = 1'b0; steps(2);
        req_in = 8'h40; steps(3);
        chk("en0_pend", pend_o, 8'h40);
        chk("en0_ei", 8'(enc_ei), 8'h00);
        steps(2);
        chk("en0_novalid", 8'(irq_valid), 8'h00);
        en = 1'b1; step();
        $display("en=1: valid=%b id=%0d", irq_valid, irq_id);
        chk("en1_valid", 8'(irq_valid), 8'h01);
        chk("en1_id", 8'(irq_id), 8'h06);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        mask = 8'hBF; req_in = 8'h00; steps(2);
        req_in = 8'h40; steps(5);
        chk("mask_novalid", 8'(irq_valid), 8'h00);
        chk("mask_pend_o", pend_o, 8'h00);
        mask = 8'hFF; #1;
        chk("mask_held", pend_o, 8'h40);
        step();
        chk("unmask_id", 8'(irq_id), 8'h06);
        chk("unmask_valid", 8'(irq_valid), 8'h01);

        // Reset during presentation, then encoder protocol violation
        req_in = 8'h00; rst = 1'b1; step(); rst = 1'b0;
        $display("reset in PRESENT: valid=%b pend=%h", irq_valid, pend_o);
        chk("rstp_valid", 8'(irq_valid), 8'h00);
        chk("rstp_id", 8'(irq_id), 8'h00);
        chk("rstp_pend", pend_o, 8'h00);
        chk("rstp_ovf", ovf, 8'h00);
        force_bad = 1'b1; step(); force_bad = 1'b0;
        chk("prot_set", 8'(prot_err), 8'h01);
        steps(3);
        chk("prot_sticky", 8'(prot_err), 8'h01);
        $display("protocol violation: prot_err=%b", prot_err);
        rst = 1'b1; step(); rst = 1'b0;
        chk("prot_rst", 8'(prot_err), 8'h00);

        // Level capture: a held request re-asserts right after service
        req0 = 8'h02; steps(3);
        chk("lvl_pend", pend_o0, 8'h02);
        step();
        chk("lvl_valid", 8'(valid0), 8'h01);
        chk("lvl_id", 8'(id0), 8'h01);
        ack0 = 1'b1; step(); ack0 = 1'b0;
        chk("lvl_pend_ack", pend_o0, 8'h02);
        chk("lvl_drop", 8'(valid0), 8'h00);
        step();
        $display("level re-present: valid=%b id=%0d", valid0, id0);
        chk("lvl_repres", 8'(valid0), 8'h01);
        chk("lvl_reid", 8'(id0), 8'h01);
        req0 = 8'h00;

        // Random traffic against the model
        rst = 1'b1; req_in = 8'h00; step(); rst = 1'b0;
        m_pend = 8'h00; m_ovf = 8'h00; m_pres = 1'b0; m_id = 3'd0;
        for (int k = 0; k < 3; k++) m_h[k] = 8'h00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [7:0] set, clr, vis;
            logic       hs;
            if ($urandom_range(0, 3) == 0) req_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            en      = ($urandom_range(0, 9) != 0);
            irq_ack = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 15) == 0);

            set = m_h[1] & ~m_h[2];
            m_h[2] = m_h[1]; m_h[1] = m_h[0]; m_h[0] = req_in;
            hs  = m_pres && irq_ack;
            clr = hs ? (8'h01 << m_id) : 8'h00;
            vis = m_pend & mask;
            if (hs) $display("rand %0d: served id=%0d", cyc, m_id);
            if (!m_pres && en && vis != 8'h00) begin
                m_pres = 1'b1; m_id = top_bit(vis);
            end else if (hs) begin
                m_pres = 1'b0;
            end
            m_ovf  = (ovf_clr ? 8'h00 : m_ovf) | (set & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | set;

            step();
            chk("rand_pend", pend_o, m_pend & mask);
            chk("rand_valid", 8'(irq_valid), 8'(m_pres));
            chk("rand_id", 8'(irq_id), 8'(m_id));
            chk("rand_ovf", ovf, m_ovf);
            chk("rand_prot", 8'(prot_err), 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
